// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: CMD codes, MIPS opcode/funct values
// and the internal operand-source selects used between the decoder and the stage.
package id_pkg;

    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_AND  = 4'd3,
        CMD_OR   = 4'd4,
        CMD_XOR  = 4'd5,
        CMD_SLL  = 4'd6,
        CMD_SRL  = 4'd7,
        CMD_SRA  = 4'd8,
        CMD_ADDI = 4'd9,
        CMD_ANDI = 4'd10,
        CMD_ORI  = 4'd11,
        CMD_XORI = 4'd12,
        CMD_LUI  = 4'd13
    } cmd_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_RRR, FMT_SHIFT, FMT_IMMS, FMT_IMMZ, FMT_LUI
    } fmt_e;

    typedef enum logic [1:0] {A_ZERO, A_PORTA, A_PORTB, A_ZIMM} asel_e;
    typedef enum logic [2:0] {B_ZERO, B_PORTB, B_SHAMT, B_SEXT, B_ZEXT} bsel_e;

endpackage

// File: rtl/id_pipe_stage_if.sv
// ID/EX output bus: registered decode results with a valid/ready handshake toward EX.
interface id_pipe_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned OP_W    = 6
);
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  rega_data;
    logic [DATA_W-1:0]  regb_data;
    logic               regc_wr;
    logic [RADDR_W-1:0] regc_addr;
    logic               illegal;

    modport master (
        output out_valid, op, rega_data, regb_data, regc_wr, regc_addr, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, op, rega_data, regb_data, regc_wr, regc_addr, illegal,
        output out_ready
    );
endinterface

// File: rtl/id_decode_comb.sv
// Pure instruction decoder: MIPS word to CMD code, register-file port usage,
// destination descriptor and operand-source selects. Unmatched encodings read nothing.
module id_decode_comb
    import id_pkg::*;
#(
    parameter int unsigned RADDR_W = 5
) (
    input  logic [31:0]        i_inst,
    output cmd_e               o_cmd,
    output logic               o_rega_rd,
    output logic [RADDR_W-1:0] o_rega_addr,
    output logic               o_regb_rd,
    output logic [RADDR_W-1:0] o_regb_addr,
    output logic               o_regc_wr,
    output logic [RADDR_W-1:0] o_regc_addr,
    output logic               o_illegal,
    output asel_e              o_asel,
    output bsel_e              o_bsel
);
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_shamt;
    cmd_e       w_cmd;
    fmt_e       w_fmt;

    assign w_opcode = i_inst[31:26];
    assign w_rs     = i_inst[25:21];
    assign w_rt     = i_inst[20:16];
    assign w_rd     = i_inst[15:11];
    assign w_shamt  = i_inst[10:6];
    assign w_funct  = i_inst[5:0];

    // R-type only matches when the unused field (shamt or rs) is zero
    always_comb begin
        w_cmd = CMD_NONE;
        w_fmt = FMT_NONE;
        case (w_opcode)
            OPC_RTYPE: begin
                case (w_funct)
                    FN_ADD:  w_cmd = CMD_ADD;
                    FN_SUB:  w_cmd = CMD_SUB;
                    FN_AND:  w_cmd = CMD_AND;
                    FN_OR:   w_cmd = CMD_OR;
                    FN_XOR:  w_cmd = CMD_XOR;
                    FN_SLL:  w_cmd = CMD_SLL;
                    FN_SRL:  w_cmd = CMD_SRL;
                    FN_SRA:  w_cmd = CMD_SRA;
                    default: w_cmd = CMD_NONE;
                endcase
                if (w_cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_XOR}) begin
                    if (w_shamt == '0) w_fmt = FMT_RRR;
                end else if (w_cmd != CMD_NONE) begin
                    if (w_rs == '0) w_fmt = FMT_SHIFT;
                end
            end
            OPC_ADDI: begin w_cmd = CMD_ADDI; w_fmt = FMT_IMMS; end
            OPC_ANDI: begin w_cmd = CMD_ANDI; w_fmt = FMT_IMMZ; end
            OPC_ORI:  begin w_cmd = CMD_ORI;  w_fmt = FMT_IMMZ; end
            OPC_XORI: begin w_cmd = CMD_XORI; w_fmt = FMT_IMMZ; end
            OPC_LUI:  begin w_cmd = CMD_LUI;  w_fmt = FMT_LUI;  end
            default:  ;
        endcase
    end

    always_comb begin
        o_cmd       = (w_fmt == FMT_NONE) ? CMD_NONE : w_cmd;
        o_rega_rd   = DISABLE;
        o_rega_addr = '0;
        o_regb_rd   = DISABLE;
        o_regb_addr = '0;
        o_regc_wr   = DISABLE;
        o_regc_addr = '0;
        o_illegal   = 1'b0;
        o_asel      = A_ZERO;
        o_bsel      = B_ZERO;
        case (w_fmt)
            FMT_RRR: begin
                o_rega_rd = ENABLE; o_rega_addr = RADDR_W'(w_rs);
                o_regb_rd = ENABLE; o_regb_addr = RADDR_W'(w_rt);
                o_regc_wr = ENABLE; o_regc_addr = RADDR_W'(w_rd);
                o_asel    = A_PORTA; o_bsel = B_PORTB;
            end
            FMT_SHIFT: begin
                o_regb_rd = ENABLE; o_regb_addr = RADDR_W'(w_rt);
                o_regc_wr = ENABLE; o_regc_addr = RADDR_W'(w_rd);
                o_asel    = A_PORTB; o_bsel = B_SHAMT;
            end
            FMT_IMMS, FMT_IMMZ: begin
                o_rega_rd = ENABLE; o_rega_addr = RADDR_W'(w_rs);
                o_regc_wr = ENABLE; o_regc_addr = RADDR_W'(w_rt);
                o_asel    = A_PORTA;
                o_bsel    = (w_fmt == FMT_IMMS) ? B_SEXT : B_ZEXT;
            end
            FMT_LUI: begin
                o_regc_wr = ENABLE; o_regc_addr = RADDR_W'(w_rt);
                o_asel    = A_ZIMM; o_bsel = B_ZERO;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Registered MIPS instruction-decode stage with ID/EX handshake and RAW hazard handling.
// `define ID_FWD_EN to forward EX/MEM results and stall only on load-use; otherwise any EX/MEM hit stalls.
module id_pipe_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    output logic               rega_rd,
    output logic [RADDR_W-1:0] rega_addr,
    output logic               regb_rd,
    output logic [RADDR_W-1:0] regb_addr,
    input  logic [DATA_W-1:0]  rega_data_i,
    input  logic [DATA_W-1:0]  regb_data_i,
    input  logic               ex_wr,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               ex_is_load,
    input  logic               mem_wr,
    input  logic [RADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0]  mem_wdata,
    id_pipe_stage_if.master    idex
);
    cmd_e               w_cmd;
    logic               w_regc_wr;
    logic [RADDR_W-1:0] w_regc_addr;
    logic               w_illegal;
    asel_e              w_asel;
    bsel_e              w_bsel;
    logic [DATA_W-1:0]  w_opa;
    logic [DATA_W-1:0]  w_opb;
    logic [DATA_W-1:0]  w_opnd_a;
    logic [DATA_W-1:0]  w_opnd_b;
    logic               w_ex_hit;
    logic               w_stall;
    logic               w_in_ready;

    logic               r_valid;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_rega_data;
    logic [DATA_W-1:0]  r_regb_data;
    logic               r_regc_wr;
    logic [RADDR_W-1:0] r_regc_addr;
    logic               r_illegal;

    id_decode_comb #(.RADDR_W(RADDR_W)) u_dec (
        .i_inst      (inst),
        .o_cmd       (w_cmd),
        .o_rega_rd   (rega_rd),
        .o_rega_addr (rega_addr),
        .o_regb_rd   (regb_rd),
        .o_regb_addr (regb_addr),
        .o_regc_wr   (w_regc_wr),
        .o_regc_addr (w_regc_addr),
        .o_illegal   (w_illegal),
        .o_asel      (w_asel),
        .o_bsel      (w_bsel)
    );

    // Disabled ports carry address 0, so address compares need no extra enable gating
    assign w_ex_hit = ex_wr && (ex_waddr != '0) &&
                      ((rega_rd && rega_addr == ex_waddr) || (regb_rd && regb_addr == ex_waddr));

`ifdef ID_FWD_EN
    always_comb begin
        w_opa = rega_data_i;
        if (rega_addr == '0)                          w_opa = '0;
        else if (ex_wr && ex_waddr == rega_addr)      w_opa = ex_wdata;
        else if (mem_wr && mem_waddr == rega_addr)    w_opa = mem_wdata;
        w_opb = regb_data_i;
        if (regb_addr == '0)                          w_opb = '0;
        else if (ex_wr && ex_waddr == regb_addr)      w_opb = ex_wdata;
        else if (mem_wr && mem_waddr == regb_addr)    w_opb = mem_wdata;
    end
    assign w_stall = w_ex_hit && ex_is_load;
`else
    logic w_mem_hit;
    logic w_unused;
    assign w_mem_hit = mem_wr && (mem_waddr != '0) &&
                       ((rega_rd && rega_addr == mem_waddr) || (regb_rd && regb_addr == mem_waddr));
    assign w_opa     = rega_data_i;
    assign w_opb     = regb_data_i;
    assign w_stall   = w_ex_hit || w_mem_hit;
    assign w_unused  = ^{ex_is_load, ex_wdata, mem_wdata};
`endif

    always_comb begin
        case (w_asel)
            A_PORTA: w_opnd_a = w_opa;
            A_PORTB: w_opnd_a = w_opb;
            A_ZIMM:  w_opnd_a = DATA_W'(inst[15:0]);
            default: w_opnd_a = '0;
        endcase
        case (w_bsel)
            B_PORTB: w_opnd_b = w_opb;
            B_SHAMT: w_opnd_b = DATA_W'(inst[10:6]);
            B_SEXT:  w_opnd_b = DATA_W'($signed(inst[15:0]));
            B_ZEXT:  w_opnd_b = DATA_W'(inst[15:0]);
            default: w_opnd_b = '0;
        endcase
    end

    assign w_in_ready = !w_stall && (!r_valid || idex.out_ready);
    assign in_ready   = w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op        <= '0;
            r_rega_data <= '0;
            r_regb_data <= '0;
            r_regc_wr   <= 1'b0;
            r_regc_addr <= '0;
            r_illegal   <= 1'b0;
        end else if (in_valid && w_in_ready) begin
            r_valid     <= 1'b1;
            r_op        <= OP_W'(w_cmd);
            r_rega_data <= w_opnd_a;
            r_regb_data <= w_opnd_b;
            r_regc_wr   <= w_regc_wr;
            r_regc_addr <= w_regc_addr;
            r_illegal   <= w_illegal;
        end else if (idex.out_ready) begin
            r_valid     <= 1'b0;
        end
    end

    assign idex.out_valid = r_valid;
    assign idex.op        = r_op;
    assign idex.rega_data = r_rega_data;
    assign idex.regb_data = r_regb_data;
    assign idex.regc_wr   = r_regc_wr;
    assign idex.regc_addr = r_regc_addr;
    assign idex.illegal   = r_illegal;

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
- Parametrised, registered successor to the combinational instruction-decode block of the MIPS_CPU core.
- Decodes one instruction per cycle into a CMD code, operand values and a destination descriptor, and holds them in an ID/EX pipeline register with a valid/ready handshake.
- Resolves RAW hazards by forwarding from EX and MEM, and stalls on load-use hazards.
- Sits between the IF stage and instruction memory on the input side, and the EX stage on the output side; reads the register file combinationally.

Parameters:
- DATA_W, 32, register and operand width (≥16).
- RADDR_W, 5, register address width.
- OP_W, 6, width of the CMD code output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  inst is valid.
- in_ready  out  1  stage accepts inst this cycle.
- inst  in  32  MIPS instruction word.
- rega_rd  out  1  register-file port A read enable (combinational from inst).
- rega_addr  out  RADDR_W  port A address (combinational).
- regb_rd  out  1  port B read enable (combinational).
- regb_addr  out  RADDR_W  port B address (combinational).
- rega_data_i  in  DATA_W  register-file port A data.
- regb_data_i  in  DATA_W  register-file port B data.
- ex_wr  in  1  EX-stage instruction writes a register.
- ex_waddr  in  RADDR_W  EX destination address.
- ex_wdata  in  DATA_W  EX result.
- ex_is_load  in  1  EX instruction is a load (result not yet available).
- mem_wr  in  1  MEM-stage instruction writes a register.
- mem_waddr  in  RADDR_W  MEM destination address.
- mem_wdata  in  DATA_W  MEM result.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts the output.
- op  out  OP_W  CMD code.
- rega_data  out  DATA_W  operand A.
- regb_data  out  DATA_W  operand B.
- regc_wr  out  1  destination write enable.
- regc_addr  out  RADDR_W  destination address.
- illegal  out  1  unrecognised encoding.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Next edge clears out_valid, op=CMD_NONE, rega_data, regb_data, regc_wr, regc_addr and illegal to 0.
  - A reset mid-stall discards the held instruction.
- Decode is combinational; the R-type shamt/rs field check is required for a match.
  - ADD/SUB/AND/OR/XOR: A=rs, B=rt, C=rd.
  - SLL/SRL/SRA: A=rt value, B=zero-extended shamt, C=rd; regb_rd=1 on rt, rega_rd=0.
  - ADDI: A=rs, B=sign-extended imm, C=rt.
  - ANDI/ORI/XORI: B=zero-extended imm.
  - LUI: A=zero-extended imm, B=0, both reads off, C=rt.
  - Disabled read ports drive address 0.
- Operand select per enabled port, in priority order:
  - Address 0 → 0.
  - Match with ex_wr && ex_waddr → ex_wdata.
  - Match with mem_wr && mem_waddr → mem_wdata.
  - Otherwise the register-file data.
- stall is asserted when ex_wr && ex_is_load && ex_waddr≠0 && ex_waddr equals any enabled read address.
- in_ready = !stall && (!out_valid || out_ready).
- Register update:
  - On in_valid && in_ready: capture the decode into the ID/EX register and set out_valid=1. Latency is 1 cycle.
  - Else if out_ready: set out_valid=0 (a bubble is inserted on stall).
  - Else: hold all outputs.
- Unrecognised opcode/funct:
  - op=CMD_NONE, regc_wr=0, illegal=1, out_valid=1.
  - Not stalled; reads are disabled.
- Simultaneous EX and MEM writes to the same address: EX wins.
- With DATA_W>32, immediates extend to DATA_W.

Optional Feature:
- ID_FWD_EN defined: forwarding as described above.
- Undefined:
  - No forwarding muxes; operands always come from the register file.
  - stall is also asserted on any enabled-read match with (ex_wr, ex_waddr≠0) or (mem_wr, mem_waddr≠0), regardless of ex_is_load.

Decomposition:
- Package id_pkg holds:
  - CMD_* constants: NONE=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, ADDI=9, ANDI=10, ORI=11, XORI=12, LUI=13.
  - Opcode/funct constants.
  - ENABLE=1 and DISABLE=0.
- One natural sub-module, id_decode_comb: the pure inst → op/addresses/enables/immediate-select decoder.
- Hazard, forwarding and pipeline register logic stay in id_pipe_stage.

Test Plan:
- rst=1 for 2 cycles, then inst=ADD $3,$1,$2 (0x00221820) with RF $1=5, $2=7 → one cycle later out_valid=1, op=1, rega_data=5, regb_data=7, regc_addr=3, regc_wr=1.
- ADDI $4,$0,-1 (0x2004FFFF) → op=9, rega_data=0, regb_data=0xFFFFFFFF; LUI $5,0x1234 → op=13, rega_data=0x00001234.
- Forwarding priority: SUB $6,$1,$2 with ex_wr=1, ex_waddr=1, ex_wdata=0x10 and mem_wr=1, mem_waddr=1, mem_wdata=0x20 → rega_data=0x10; with ex_wr=0 → rega_data=0x20.
- Load-use: ex_is_load=1, ex_wr=1, ex_waddr=2, inst reads $2 → in_ready=0 and out_valid=0 next cycle; clear ex_is_load → accepted one cycle later.
- Backpressure: out_ready=0 with out_valid=1 → outputs hold, in_ready=0; assert rst while held → out_valid=0 next edge.
- Illegal: inst=0xFC000000 → op=0, illegal=1, regc_wr=0, out_valid=1.
